// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_sequencer
// Keypad calculator sequencer: operand entry, ALU handshake and watchdog.
// Optional decimal-entry restriction is enabled with macro CALC_DEC_MODE_EN.
// Revision : 1.0
// ============================================================================
module calc_sequencer #(
    parameter int DIGITS    = 4,
    parameter int WD_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_press,
    input  logic [4:0]            key_val,
    input  logic                  dec_mode,
    input  logic [4*DIGITS-1:0]   alu_result,
    input  logic                  alu_done,
    output logic                  restriction,
    output logic [4*DIGITS-1:0]   op_a,
    output logic [4*DIGITS-1:0]   op_b,
    output logic [2:0]            alu_op,
    output logic                  alu_start,
    output logic [4*DIGITS-1:0]   disp_val,
    output logic                  busy,
    output logic                  err
);

    localparam int C_W     = 4 * DIGITS;
    localparam int C_CNT_W = $clog2(DIGITS + 1);
    localparam int C_WD_W  = (WD_CYCLES < 2) ? 1 : $clog2(WD_CYCLES + 1);

    localparam logic [C_CNT_W-1:0] C_MAX_CNT = C_CNT_W'(DIGITS);
    localparam logic [C_WD_W-1:0]  C_WD_LOAD = C_WD_W'(WD_CYCLES);

    localparam logic [4:0] C_KEY_ADD = 5'h10;
    localparam logic [4:0] C_KEY_MUL = 5'h11;
    localparam logic [4:0] C_KEY_AND = 5'h12;
    localparam logic [4:0] C_KEY_EXE = 5'h13;
    localparam logic [4:0] C_KEY_SUB = 5'h14;
    localparam logic [4:0] C_KEY_OR  = 5'h15;
    localparam logic [4:0] C_KEY_CE  = 5'h16;
    localparam logic [4:0] C_KEY_CLR = 5'h17;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_RES  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [C_W-1:0]       op_a_q, op_a_d;
    logic [C_W-1:0]       op_b_q, op_b_d;
    logic [2:0]           alu_op_q, alu_op_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [C_WD_W-1:0]    wd_q, wd_d;
    logic                 alu_start_q, alu_start_d;
    logic                 err_q, err_d;

    logic                 w_is_digit;
    logic                 w_digit_ok;
    logic                 w_is_op;
    logic [2:0]           w_op_code;
    logic                 w_is_exe;
    logic                 w_is_ce;
    logic                 w_is_clr;
    logic                 w_cnt_room;
    logic [C_W-1:0]       w_digit_ext;

    assign w_is_digit  = key_press && (key_val[4] == 1'b0);
    assign w_is_exe    = key_press && (key_val == C_KEY_EXE);
    assign w_is_ce     = key_press && (key_val == C_KEY_CE);
    assign w_is_clr    = key_press && (key_val == C_KEY_CLR);
    assign w_cnt_room  = (cnt_q < C_MAX_CNT);
    assign w_digit_ext = C_W'(key_val[3:0]);

`ifdef CALC_DEC_MODE_EN
    logic restr_q;

    // Restriction lags dec_mode by one cycle; hex digits are refused while it is set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            restr_q <= 1'b0;
        end else begin
            restr_q <= dec_mode;
        end
    end

    assign restriction = restr_q;
    assign w_digit_ok  = w_is_digit && !(restr_q && (key_val[3:0] > 4'd9));
`else
    logic w_unused_dec;

    assign w_unused_dec = dec_mode;
    assign restriction  = 1'b0;
    assign w_digit_ok   = w_is_digit;
`endif

    always_comb begin
        w_is_op   = 1'b0;
        w_op_code = 3'd0;
        if (key_press) begin
            case (key_val)
                C_KEY_ADD: begin w_is_op = 1'b1; w_op_code = 3'd0; end
                C_KEY_SUB: begin w_is_op = 1'b1; w_op_code = 3'd1; end
                C_KEY_MUL: begin w_is_op = 1'b1; w_op_code = 3'd2; end
                C_KEY_AND: begin w_is_op = 1'b1; w_op_code = 3'd3; end
                C_KEY_OR:  begin w_is_op = 1'b1; w_op_code = 3'd4; end
                default:   ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        alu_op_d    = alu_op_q;
        cnt_d       = cnt_q;
        wd_d        = wd_q;
        alu_start_d = 1'b0;
        err_d       = err_q;

        if (w_is_clr) begin
            // CLR is honoured everywhere, including an in-flight ALU operation.
            state_d  = S_A;
            op_a_d   = '0;
            op_b_d   = '0;
            alu_op_d = 3'd0;
            cnt_d    = '0;
            wd_d     = '0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                S_A: begin
                    if (w_digit_ok) begin
                        if (w_cnt_room) begin
                            op_a_d = {op_a_q[C_W-5:0], key_val[3:0]};
                            cnt_d  = cnt_q + C_CNT_W'(1);
                        end
                    end else if (w_is_op) begin
                        alu_op_d = w_op_code;
                        op_b_d   = '0;
                        cnt_d    = '0;
                        state_d  = S_B;
                    end else if (w_is_ce) begin
                        op_a_d = '0;
                        cnt_d  = '0;
                    end
                end

                S_B: begin
                    if (w_digit_ok) begin
                        if (w_cnt_room) begin
                            op_b_d = {op_b_q[C_W-5:0], key_val[3:0]};
                            cnt_d  = cnt_q + C_CNT_W'(1);
                        end
                    end else if (w_is_op) begin
                        alu_op_d = w_op_code;
                    end else if (w_is_ce) begin
                        op_b_d = '0;
                        cnt_d  = '0;
                    end else if (w_is_exe) begin
                        alu_start_d = 1'b1;
                        wd_d        = C_WD_LOAD;
                        state_d     = S_EXEC;
                    end
                end

                S_EXEC: begin
                    // wd_q == 1 marks the last permitted waiting cycle.
                    if (alu_done) begin
                        op_a_d  = alu_result;
                        cnt_d   = '0;
                        wd_d    = '0;
                        state_d = S_RES;
                    end else if (wd_q <= C_WD_W'(1)) begin
                        err_d   = 1'b1;
                        op_a_d  = '0;
                        op_b_d  = '0;
                        cnt_d   = '0;
                        wd_d    = '0;
                        state_d = S_A;
                    end else begin
                        wd_d = wd_q - C_WD_W'(1);
                    end
                end

                S_RES: begin
                    if (w_digit_ok) begin
                        op_a_d  = w_digit_ext;
                        cnt_d   = C_CNT_W'(1);
                        state_d = S_A;
                    end else if (w_is_op) begin
                        alu_op_d = w_op_code;
                        op_b_d   = '0;
                        cnt_d    = '0;
                        state_d  = S_B;
                    end else if (w_is_ce) begin
                        op_a_d  = '0;
                        cnt_d   = '0;
                        state_d = S_A;
                    end
                end

                default: begin
                    state_d = S_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_A;
            op_a_q      <= '0;
            op_b_q      <= '0;
            alu_op_q    <= 3'd0;
            cnt_q       <= '0;
            wd_q        <= '0;
            alu_start_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            alu_op_q    <= alu_op_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            alu_start_q <= alu_start_d;
            err_q       <= err_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign alu_op    = alu_op_q;
    assign alu_start = alu_start_q;
    assign err       = err_q;
    assign busy      = (state_q == S_EXEC);
    assign disp_val  = ((state_q == S_A) || (state_q == S_RES)) ? op_a_q : op_b_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_sequencer
// Self-checking bench for calc_sequencer: directed scenarios plus random keys
// against a digit-queue reference model. Honours CALC_DEC_MODE_EN if defined.
// Revision : 1.0
// ============================================================================
module tb_calc_sequencer;

    localparam int DIGITS = 4;
    localparam int WD     = 255;
    localparam int W      = 4 * DIGITS;

    localparam logic [4:0] K_ADD = 5'h10, K_MUL = 5'h11, K_AND = 5'h12, K_EXE = 5'h13;
    localparam logic [4:0] K_SUB = 5'h14, K_OR  = 5'h15, K_CE  = 5'h16, K_CLR = 5'h17;

    localparam int M_A = 0, M_B = 1, M_EXEC = 2, M_RES = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_press = 1'b0;
    logic [4:0]   key_val = 5'd0;
    logic         dec_mode = 1'b0;
    logic [W-1:0] alu_result = '0;
    logic         alu_done = 1'b0;
    logic         restriction;
    logic [W-1:0] op_a, op_b, disp_val;
    logic [2:0]   alu_op;
    logic         alu_start, busy, err;

    int n_checks = 0;
    int n_fail   = 0;

    calc_sequencer #(.DIGITS(DIGITS), .WD_CYCLES(WD)) dut (
        .clk(clk), .rst(rst), .key_press(key_press), .key_val(key_val),
        .dec_mode(dec_mode), .alu_result(alu_result), .alu_done(alu_done),
        .restriction(restriction), .op_a(op_a), .op_b(op_b), .alu_op(alu_op),
        .alu_start(alu_start), .disp_val(disp_val), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] k);
        key_press = 1'b1;
        key_val   = k;
        tick();
        key_press = 1'b0;
        key_val   = 5'd0;
    endtask

    // ---------------- reference model ----------------
    int           m_mode;
    int           m_aq[$];
    int           m_bq[$];
    logic [W-1:0] m_abase;
    logic [2:0]   m_op;
    bit           m_err, m_start, m_restr;
    int           m_wait;

    function automatic logic [W-1:0] fold(input int q[$]);
        logic [31:0] v = 0;
        foreach (q[i]) v = v * 16 + q[i];
        return v[W-1:0];
    endfunction

    function automatic logic [W-1:0] a_val();
        return (m_aq.size() == 0) ? m_abase : fold(m_aq);
    endfunction

    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] op);
        logic [31:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a * b;
            3'd3:    r = a & b;
            default: r = a | b;
        endcase
        return r[W-1:0];
    endfunction

    task automatic model_init();
        m_mode = M_A; m_aq.delete(); m_bq.delete(); m_abase = '0;
        m_op = 3'd0; m_err = 1'b0; m_start = 1'b0; m_wait = 0;
    endtask

    task automatic mstep(input bit kp, input logic [4:0] kv, input bit dm,
                         input bit done, input logic [W-1:0] res);
        bit dig_ok;
        int opc;
        dig_ok  = kp && (kv < 16) && !(m_restr && (kv[3:0] > 9));
        opc     = -1;
        if (kp) begin
            if (kv == K_ADD) opc = 0;
            if (kv == K_SUB) opc = 1;
            if (kv == K_MUL) opc = 2;
            if (kv == K_AND) opc = 3;
            if (kv == K_OR)  opc = 4;
        end
        m_start = 1'b0;
        if (kp && kv == K_CLR) begin
            model_init();
        end else if (m_mode == M_A) begin
            if (dig_ok) begin
                if (m_aq.size() < DIGITS) m_aq.push_back(int'(kv[3:0]));
            end else if (opc >= 0) begin
                m_op = 3'(opc); m_bq.delete(); m_mode = M_B;
            end else if (kp && kv == K_CE) begin
                m_aq.delete(); m_abase = '0;
            end
        end else if (m_mode == M_B) begin
            if (dig_ok) begin
                if (m_bq.size() < DIGITS) m_bq.push_back(int'(kv[3:0]));
            end else if (opc >= 0) begin
                m_op = 3'(opc);
            end else if (kp && kv == K_CE) begin
                m_bq.delete();
            end else if (kp && kv == K_EXE) begin
                m_start = 1'b1; m_wait = 0; m_mode = M_EXEC;
            end
        end else if (m_mode == M_EXEC) begin
            if (done) begin
                m_aq.delete(); m_abase = res; m_mode = M_RES;
            end else begin
                m_wait++;
                if (m_wait >= WD) begin
                    m_err = 1'b1; m_aq.delete(); m_abase = '0; m_bq.delete(); m_mode = M_A;
                end
            end
        end else begin
            if (dig_ok) begin
                m_aq.delete(); m_abase = '0; m_aq.push_back(int'(kv[3:0])); m_mode = M_A;
            end else if (opc >= 0) begin
                m_op = 3'(opc); m_bq.delete(); m_mode = M_B;
            end else if (kp && kv == K_CE) begin
                m_aq.delete(); m_abase = '0; m_mode = M_A;
            end
        end
`ifdef CALC_DEC_MODE_EN
        m_restr = dm;
`else
        m_restr = 1'b0;
        if (dm) m_restr = 1'b0;
`endif
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        #2;
        n_checks++;
        if ({op_a, op_b, disp_val, alu_op} !== '0) begin
            n_fail++; $display("FAIL reset_data: got a=%h b=%h d=%h op=%0d, want all 0", op_a, op_b, disp_val, alu_op);
        end
        n_checks++;
        if ({alu_start, busy, err, restriction} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got start/busy/err/restr=%b, want 0000", {alu_start, busy, err, restriction});
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic_add();
        press(K_CLR);
        press(5'h1); press(5'h2); press(K_ADD); press(5'h3);
        press(K_EXE);
        n_checks++;
        if ({alu_start, busy} !== 2'b11 || op_a !== 16'h0012 || op_b !== 16'h0003 || alu_op !== 3'd0) begin
            n_fail++; $display("FAIL basic_start: got start=%b busy=%b a=%h b=%h op=%0d, want 1 1 0012 0003 0",
                               alu_start, busy, op_a, op_b, alu_op);
        end
        tick();
        n_checks++;
        if (alu_start !== 1'b0 || disp_val !== 16'h0003) begin
            n_fail++; $display("FAIL basic_pulse: got start=%b disp=%h, want 0 0003", alu_start, disp_val);
        end
        tick();
        alu_done = 1'b1; alu_result = 16'h0015;
        tick();
        alu_done = 1'b0; alu_result = '0;
        n_checks++;
        if (busy !== 1'b0 || disp_val !== 16'h0015 || op_a !== 16'h0015) begin
            n_fail++; $display("FAIL basic_result: got busy=%b disp=%h a=%h, want 0 0015 0015", busy, disp_val, op_a);
        end
    endtask

    task automatic test_entry();
        press(K_CLR);
        press(5'h1); press(5'h2); press(5'h3); press(5'h4); press(5'h5);
        n_checks++;
        if (op_a !== 16'h1234 || disp_val !== 16'h1234) begin
            n_fail++; $display("FAIL digit_limit: got a=%h disp=%h, want 1234", op_a, disp_val);
        end
        press(K_EXE);
        n_checks++;
        if (alu_start !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL exe_in_a: got start=%b busy=%b, want 0 0", alu_start, busy);
        end
        press(K_CE); press(5'h6); press(K_ADD); press(5'h7); press(5'h8);
        n_checks++;
        if (op_a !== 16'h0006 || op_b !== 16'h0078 || disp_val !== 16'h0078) begin
            n_fail++; $display("FAIL operand_b: got a=%h b=%h disp=%h, want 0006 0078 0078", op_a, op_b, disp_val);
        end
        press(K_CE); press(K_SUB); press(K_MUL);
        n_checks++;
        if (op_a !== 16'h0006 || op_b !== 16'h0000 || alu_op !== 3'd2) begin
            n_fail++; $display("FAIL ce_and_op_replace: got a=%h b=%h op=%0d, want 0006 0000 2", op_a, op_b, alu_op);
        end
    endtask

    task automatic test_watchdog();
        press(K_CLR);
        press(5'h1); press(K_ADD); press(5'h2); press(K_EXE);
        repeat (WD - 1) tick();
        n_checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL wd_early: got busy=%b err=%b, want 1 0", busy, err);
        end
        tick();
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || op_a !== '0 || op_b !== '0 || disp_val !== '0) begin
            n_fail++; $display("FAIL wd_expire: got err=%b busy=%b a=%h b=%h, want 1 0 0 0", err, busy, op_a, op_b);
        end
        press(5'h9);
        n_checks++;
        if (op_a !== 16'h0009 || err !== 1'b1) begin
            n_fail++; $display("FAIL wd_sticky: got a=%h err=%b, want 0009 1", op_a, err);
        end
        press(K_CLR);
        n_checks++;
        if (err !== 1'b0 || op_a !== '0) begin
            n_fail++; $display("FAIL clr_err: got err=%b a=%h, want 0 0", err, op_a);
        end
    endtask

    task automatic test_clr_abort();
        press(K_CLR);
        press(5'h9); press(K_ADD); press(5'h1); press(K_EXE);
        press(5'h7); press(K_SUB); press(K_CE);
        n_checks++;
        if (busy !== 1'b1 || op_a !== 16'h0009 || op_b !== 16'h0001 || alu_op !== 3'd0) begin
            n_fail++; $display("FAIL exec_keys_ignored: got busy=%b a=%h b=%h op=%0d, want 1 0009 0001 0",
                               busy, op_a, op_b, alu_op);
        end
        press(K_CLR);
        alu_done = 1'b1; alu_result = 16'hBEEF;
        tick();
        alu_done = 1'b0; alu_result = '0;
        n_checks++;
        if (busy !== 1'b0 || op_a !== '0 || disp_val !== '0 || op_b !== '0) begin
            n_fail++; $display("FAIL clr_abort: got busy=%b a=%h b=%h disp=%h, want 0 0 0 0", busy, op_a, op_b, disp_val);
        end
    endtask

    task automatic test_chain();
        press(K_CLR);
        press(5'h4); press(K_MUL); press(5'h2); press(K_EXE);
        key_press = 1'b1; key_val = 5'h5;
        alu_done = 1'b1; alu_result = 16'h0042;
        tick();
        key_press = 1'b0; key_val = 5'd0; alu_done = 1'b0; alu_result = '0;
        n_checks++;
        if (op_a !== 16'h0042 || disp_val !== 16'h0042) begin
            n_fail++; $display("FAIL done_with_key: got a=%h disp=%h, want 0042", op_a, disp_val);
        end
        press(K_EXE); press(K_OR); press(5'h3); press(K_EXE);
        n_checks++;
        if (alu_start !== 1'b1 || op_a !== 16'h0042 || op_b !== 16'h0003 || alu_op !== 3'd4) begin
            n_fail++; $display("FAIL chain_start: got start=%b a=%h b=%h op=%0d, want 1 0042 0003 4",
                               alu_start, op_a, op_b, alu_op);
        end
        alu_done = 1'b1; alu_result = 16'h0043;
        tick();
        alu_done = 1'b0;
        press(5'h7);
        n_checks++;
        if (op_a !== 16'h0007 || busy !== 1'b0) begin
            n_fail++; $display("FAIL res_digit: got a=%h busy=%b, want 0007 0", op_a, busy);
        end
    endtask

    task automatic test_dec_mode();
        press(K_CLR);
        dec_mode = 1'b1;
        tick();
        press(5'hA); press(5'h5);
`ifdef CALC_DEC_MODE_EN
        n_checks++;
        if (restriction !== 1'b1 || op_a !== 16'h0005) begin
            n_fail++; $display("FAIL dec_restrict: got restr=%b a=%h, want 1 0005", restriction, op_a);
        end
        dec_mode = 1'b0;
        tick();
        press(5'hB);
        n_checks++;
        if (restriction !== 1'b0 || op_a !== 16'h005B) begin
            n_fail++; $display("FAIL dec_release: got restr=%b a=%h, want 0 005B", restriction, op_a);
        end
`else
        n_checks++;
        if (restriction !== 1'b0 || op_a !== 16'h00A5) begin
            n_fail++; $display("FAIL dec_disabled: got restr=%b a=%h, want 0 00A5", restriction, op_a);
        end
        dec_mode = 1'b0;
        tick();
`endif
    endtask

    task automatic test_async_reset();
        press(K_CLR);
        press(5'h4); press(K_ADD); press(5'h6);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({op_a, op_b, disp_val, alu_op, alu_start, busy, err, restriction} !== '0) begin
            n_fail++; $display("FAIL async_reset: got a=%h b=%h disp=%h op=%0d start=%b busy=%b err=%b, want all 0",
                               op_a, op_b, disp_val, alu_op, alu_start, busy, err);
        end
        #1;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_random();
        bit           kp, dn, dm;
        logic [4:0]   kv;
        logic [W-1:0] rs;
        logic [W-1:0] exp_disp;
        int           lat;
        int           r;
        dec_mode = 1'b0;
        tick(); tick();
        press(K_CLR);
        model_init();
        m_restr = 1'b0;
        lat = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            kp = 1'b0; kv = 5'd0; dn = 1'b0; rs = '0;
            dm = ($urandom_range(0, 24) == 0) ? ~dec_mode : dec_mode;
            if (m_mode == M_EXEC) begin
                if (lat == 0) begin
                    dn = 1'b1; rs = alu_ref(a_val(), fold(m_bq), m_op);
                end else begin
                    lat--;
                end
                if ($urandom_range(0, 7) == 0) begin
                    kp = 1'b1;
                    kv = ($urandom_range(0, 3) == 0) ? K_CLR : 5'($urandom_range(0, 31));
                end
            end else begin
                if ($urandom_range(0, 19) == 0) begin dn = 1'b1; rs = W'($urandom); end
                if ($urandom_range(0, 9) < 7) begin
                    kp = 1'b1;
                    r  = $urandom_range(0, 99);
                    if (r < 50)      kv = 5'($urandom_range(0, 15));
                    else if (r < 70) kv = 5'($urandom_range(16, 21));
                    else if (r < 82) kv = K_EXE;
                    else if (r < 88) kv = K_CE;
                    else if (r < 91) kv = K_CLR;
                    else             kv = 5'($urandom_range(24, 31));
                end
            end
            key_press = kp; key_val = kv; alu_done = dn; alu_result = rs; dec_mode = dm;
            mstep(kp, kv, dm, dn, rs);
            tick();
            if (m_start) lat = $urandom_range(0, 4);
            exp_disp = (m_mode == M_A || m_mode == M_RES) ? a_val() : fold(m_bq);
            n_checks++;
            if (op_a !== a_val() || op_b !== fold(m_bq)) begin
                n_fail++; $display("FAIL rnd_operands cyc=%0d: got a=%h b=%h, want a=%h b=%h", cyc, op_a, op_b, a_val(), fold(m_bq));
            end
            n_checks++;
            if (disp_val !== exp_disp) begin
                n_fail++; $display("FAIL rnd_disp cyc=%0d: got %h, want %h", cyc, disp_val, exp_disp);
            end
            n_checks++;
            if ({alu_start, busy, err, restriction, alu_op} !==
                {m_start, (m_mode == M_EXEC), m_err, m_restr, m_op}) begin
                n_fail++; $display("FAIL rnd_ctrl cyc=%0d: got start/busy/err/restr=%b%b%b%b op=%0d, want %b%b%b%b op=%0d",
                                   cyc, alu_start, busy, err, restriction, alu_op,
                                   m_start, (m_mode == M_EXEC), m_err, m_restr, m_op);
            end
        end
        key_press = 1'b0; key_val = 5'd0; alu_done = 1'b0; alu_result = '0; dec_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_entry();
        test_watchdog();
        test_clr_abort();
        test_chain();
        test_dec_mode();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the maximum digits per operand; operand width is 4*DIGITS bits.
REQ-002 The block SHALL have parameter WD_CYCLES, default 255, giving the ALU watchdog limit in clock cycles.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port key_press, input, 1 bit: one-cycle strobe meaning key_val is valid.
REQ-006 The block SHALL have port key_val, input, 5 bits: key code from the grid cursor. 0x00-0x0F are digits, 0x10 ADD, 0x11 MUL, 0x12 AND, 0x13 EXE, 0x14 SUB, 0x15 OR, 0x16 CE, 0x17 CLR; all other codes are ignored.
REQ-007 The block SHALL have port dec_mode, input, 1 bit: decimal entry mode request.
REQ-008 The block SHALL have port alu_result, input, 4*DIGITS bits: ALU output.
REQ-009 The block SHALL have port alu_done, input, 1 bit: ALU completion strobe.
REQ-010 The block SHALL have port restriction, output, 1 bit: cursor restriction to the grid cursor.
REQ-011 The block SHALL have ports op_a and op_b, outputs, 4*DIGITS bits each: ALU operands.
REQ-012 The block SHALL have port alu_op, output, 3 bits: ADD=0, SUB=1, MUL=2, AND=3, OR=4.
REQ-013 The block SHALL have port alu_start, output, 1 bit: one-cycle ALU start pulse.
REQ-014 The block SHALL have port disp_val, output, 4*DIGITS bits: value to display.
REQ-015 The block SHALL have port busy, output, 1 bit: asserted in S_EXEC.
REQ-016 The block SHALL have port err, output, 1 bit: sticky watchdog error flag.

Function
REQ-017 The FSM SHALL have states S_A (enter A), S_B (enter B), S_EXEC (wait ALU) and S_RES (show result).
REQ-018 A digit in S_A or S_B SHALL shift the active operand left 4 bits and insert the digit in the low nibble; digits beyond DIGITS per operand SHALL be ignored (counter saturates).
REQ-019 An operator in S_A SHALL latch alu_op, clear op_b and the digit count, and go to S_B; an operator in S_B SHALL only replace alu_op.
REQ-020 EXE in S_B SHALL pulse alu_start for exactly one cycle, load the watchdog and go to S_EXEC; EXE in S_A or S_RES SHALL be ignored.
REQ-021 In S_EXEC, alu_done SHALL latch alu_result into op_a, set digit count 0 and go to S_RES next cycle; all keys except CLR SHALL be ignored, including a key coincident with alu_done.
REQ-022 If alu_done is absent for WD_CYCLES cycles after alu_start, the block SHALL set err, clear operands and go to S_A.
REQ-023 In S_RES a digit SHALL start a new op_a containing that digit (S_A) and an operator SHALL chain (op_a kept, go to S_B).
REQ-024 CE SHALL clear the active operand and its count: S_A clears A, S_B clears B, S_RES goes to S_A with A=0; CE in S_EXEC SHALL be ignored.
REQ-025 CLR in any state SHALL clear op_a, op_b, alu_op, count and err and go to S_A; CLR in S_EXEC aborts, and a later alu_done SHALL be ignored.
REQ-026 disp_val SHALL equal op_a in S_A and S_RES, and op_b in S_B and S_EXEC.
REQ-027 A change of dec_mode SHALL leave operand digits already entered unchanged.

Reset
REQ-028 On rst low, the block SHALL asynchronously set state S_A; op_a, op_b, disp_val, alu_op, count and watchdog to 0; and alu_start, busy, err and restriction to 0.

Configuration
REQ-029 With macro CALC_DEC_MODE_EN defined, restriction SHALL equal dec_mode registered (one-cycle delay), and digits 0xA-0xF SHALL be ignored while restriction=1.
REQ-030 Without CALC_DEC_MODE_EN, restriction SHALL be tied 0, dec_mode SHALL be unused, and all 16 digits SHALL be accepted.

Verification
REQ-031 Keys 1,2,ADD,3,EXE; ALU returns 0x0015 after 3 cycles -> alu_start is one pulse with op_a=0x0012, op_b=0x0003, alu_op=0; state is S_RES with disp_val=0x0015.
REQ-032 Keys 1,2,3,4,5 -> op_a=0x1234, fifth digit ignored.
REQ-033 EXE issued with alu_done withheld for 255 cycles -> err=1, state S_A, op_a=0.
REQ-034 Sequence 7,SUB,CLR issued during S_EXEC, then alu_done -> state stays S_A, op_a=0, no result is latched.
REQ-035 With CALC_DEC_MODE_EN defined and dec_mode=1, keys 0xA,5 -> restriction=1, op_a=0x0005.
REQ-036 rst asserted mid-S_B without a clock edge -> all outputs take their reset values immediately.
